ikascc_bus_sequencer: RTL and testbench
=======================================

// Module: ikascc_bus_sequencer
// PURPOSE
//  Two-port bus master in front of the IKASCC slave bus. Arbitrates between two
//  requesters (port 0 = host CPU bridge, port 1 = playback engine). Turns each
//  granted register access into a timed CS_n/RD_n/WR_n/AB/DB cycle.
//  All timing is paced by the same MCLK prescaler enable that clocks IKASCC.
// PARAMETERS
//  STROBE_CYC  2  PCEN ticks that CS_n and RD_n/WR_n stay low (legal 1..15)
//  RR          1  1 = round-robin arbitration, 0 = fixed priority (port 0 wins)
// PORTS
//  i_EMUCLK        in   1   system clock
//  i_RST           in   1   asynchronous, active-high reset
//  i_MCLK_PCEN_n   in   1   active-low tick enable; FSM advances only when low
//  i_REQ           in   2   per-port request; hold high until the matching o_ACK
//  i_WE            in   2   per-port 1 = write, 0 = read
//  i_ADDR0/1       in   16  per-port SCC bus address
//  i_WDATA0/1      in   8   per-port write data
//  o_ACK           out  2   one-clock completion pulse, per port
//  o_RDATA         out  8   read data; valid from the o_ACK pulse until next read ack
//  o_BUSY          out  1   high whenever the FSM is not IDLE
//  o_CS_n          out  1   to IKASCC i_CS_n
//  o_RD_n          out  1   to IKASCC i_RD_n
//  o_WR_n          out  1   to IKASCC i_WR_n
//  o_AB            out  16  to IKASCC i_ABLO / i_ABHI
//  o_DB            out  8   write data to IKASCC i_DB
//  o_DB_OE         out  1   high while o_DB is driven
//  i_DB            in   8   read data from IKASCC o_DB
// BEHAVIOUR
//  Reset (async, all outputs):
//   - o_CS_n, o_RD_n, o_WR_n = 1; o_AB = 0; o_DB = 0; o_DB_OE = 0.
//   - o_ACK = 0; o_RDATA = 0; o_BUSY = 0.
//   - FSM = IDLE, round-robin pointer = port 0.
//  Tick = rising edge of i_EMUCLK with i_MCLK_PCEN_n == 0. State changes happen only on ticks.
//  States, with the tick that leaves each one:
//   - IDLE: any i_REQ high at a tick -> arbitrate, latch addr/we/wdata/port, go to SETUP.
//     o_AB updates at this tick; for writes o_DB is loaded and o_DB_OE = 1.
//   - SETUP (1 tick): all strobes high. Next tick: o_CS_n = 0, plus o_WR_n = 0 or
//     o_RD_n = 0; go to ACTIVE; strobe counter = 0.
//   - ACTIVE (STROBE_CYC ticks): counter increments each tick.
//     The tick with counter == STROBE_CYC-1 does all of: o_RDATA <= i_DB (reads only),
//     strobes and o_CS_n go high, go to RECOVER.
//   - RECOVER (1 tick): o_AB and o_DB are held. Next tick: o_DB_OE = 0;
//     o_ACK[port] = 1 for exactly one i_EMUCLK; go to IDLE.
//  Latency: accept tick T0, ack at tick T0 + STROBE_CYC + 2. IDLE can accept a new
//  request on the same tick that issues the ack (back-to-back, no gap tick).
//  Arbitration (IDLE ticks only):
//   - RR = 1: on a tie, grant goes to the port not granted last; pointer updates on grant.
//   - RR = 0: port 0 always wins.
//   - A single requester is granted immediately.
//  Boundary cases:
//   - Request dropped before its ack: the cycle still completes and the ack is still issued.
//   - i_MCLK_PCEN_n held high: FSM freezes in place, outputs hold.
//   - o_AB keeps the last address while IDLE; o_RD_n and o_WR_n are never low together.
//   - Reset mid-cycle: strobes and o_CS_n deassert immediately; no ack; the requester
//     must reissue after reset.
// TESTING (PCEN every 8th clock, STROBE_CYC=2, RR=1)
//  1 P0 write 9000h<-3Fh -> o_AB=9000h at T0; CS_n/WR_n low for T1..T2; DB_OE T0..T3;
//    ACK[0] at T4, one clock wide.
//  2 P1 read 9860h with i_DB=A5h -> RD_n low for T1..T2; o_RDATA=A5h and ACK[1] at T4;
//    WR_n stays high throughout.
//  3 P0 and P1 both request on the same tick, repeated 4 times -> grant order 0,1,0,1;
//    no tick gap between cycles; RR=0 rerun gives all port-0 grants first.
//  4 Hold i_MCLK_PCEN_n high for 20 clocks while in ACTIVE -> strobes stay low and state
//    freezes; the cycle resumes with identical tick counts.
//  5 Assert i_RST during ACTIVE of a write -> CS_n/WR_n go to 1 and o_DB_OE to 0
//    within the same clock; no ACK; the next request after reset runs normally.
//  6 STROBE_CYC=1 and 15 builds -> ack at T3 and T17 respectively; never RD_n=WR_n=0.

Source files
------------

// File: rtl/ikascc_bus_sequencer.sv
// ikascc_bus_sequencer: two-port arbiter and bus-cycle generator for IKASCC.
// Ports: i_EMUCLK/i_RST clock+async reset, i_MCLK_PCEN_n tick enable,
//   i_REQ/i_WE/i_ADDR0/1/i_WDATA0/1 requester side, o_ACK/o_RDATA/o_BUSY status,
//   o_CS_n/o_RD_n/o_WR_n/o_AB/o_DB/o_DB_OE/i_DB slave bus side.
module ikascc_bus_sequencer #(
   parameter int unsigned STROBE_CYC = 2,
   parameter bit          RR         = 1'b1
) (
   input  logic        i_EMUCLK,
   input  logic        i_RST,
   input  logic        i_MCLK_PCEN_n,
   input  logic [1:0]  i_REQ,
   input  logic [1:0]  i_WE,
   input  logic [15:0] i_ADDR0,
   input  logic [15:0] i_ADDR1,
   input  logic [7:0]  i_WDATA0,
   input  logic [7:0]  i_WDATA1,
   output logic [1:0]  o_ACK,
   output logic [7:0]  o_RDATA,
   output logic        o_BUSY,
   output logic        o_CS_n,
   output logic        o_RD_n,
   output logic        o_WR_n,
   output logic [15:0] o_AB,
   output logic [7:0]  o_DB,
   output logic        o_DB_OE,
   input  logic [7:0]  i_DB
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACTIVE,
      ST_RECOVER
   } state_t;

   localparam logic [3:0] LP_LAST = 4'(STROBE_CYC - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_port;
   logic        r_we;
   logic        r_ptr;

   logic        w_tick;
   logic [1:0]  w_mask;
   logic [1:0]  w_req;
   logic        w_gnt;
   logic        w_accept;
   logic [15:0] w_addr;
   logic [7:0]  w_wdata;
   logic        w_we;

   assign w_tick = ~i_MCLK_PCEN_n;

   // The port being acked on a RECOVER tick still shows its old request;
   // hide it so a back-to-back grant never re-serves the same access.
   assign w_mask = (r_state == ST_RECOVER) ?
                   (r_port ? 2'b10 : 2'b01) : 2'b00;
   assign w_req  = i_REQ & ~w_mask;

   // r_ptr is the port preferred on the next tie.
   assign w_gnt = (w_req == 2'b11) ? (RR ? r_ptr : 1'b0) : w_req[1];

   assign w_accept = w_tick && (|w_req) &&
                     ((r_state == ST_IDLE) || (r_state == ST_RECOVER));

   assign w_addr  = w_gnt ? i_ADDR1  : i_ADDR0;
   assign w_wdata = w_gnt ? i_WDATA1 : i_WDATA0;
   assign w_we    = i_WE[w_gnt];

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_port  <= 1'b0;
         r_we    <= 1'b0;
         r_ptr   <= 1'b0;
         o_ACK   <= '0;
         o_RDATA <= '0;
         o_BUSY  <= 1'b0;
         o_CS_n  <= 1'b1;
         o_RD_n  <= 1'b1;
         o_WR_n  <= 1'b1;
         o_AB    <= '0;
         o_DB    <= '0;
         o_DB_OE <= 1'b0;
      end else begin
         o_ACK <= '0;
         if (w_tick) begin
            unique case (r_state)
               ST_IDLE: begin
               end
               ST_SETUP: begin
                  o_CS_n  <= 1'b0;
                  o_WR_n  <= ~r_we;
                  o_RD_n  <= r_we;
                  r_cnt   <= '0;
                  r_state <= ST_ACTIVE;
               end
               ST_ACTIVE: begin
                  if (r_cnt == LP_LAST) begin
                     if (!r_we) o_RDATA <= i_DB;
                     o_CS_n  <= 1'b1;
                     o_RD_n  <= 1'b1;
                     o_WR_n  <= 1'b1;
                     r_state <= ST_RECOVER;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               ST_RECOVER: begin
                  o_DB_OE       <= 1'b0;
                  o_ACK[r_port] <= 1'b1;
                  o_BUSY        <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            endcase
            // Acceptance overrides the RECOVER exit so cycles chain
            // without an idle tick in between.
            if (w_accept) begin
               r_port  <= w_gnt;
               r_we    <= w_we;
               o_AB    <= w_addr;
               o_DB_OE <= w_we;
               if (w_we) o_DB <= w_wdata;
               if (RR) r_ptr <= ~w_gnt;
               o_BUSY  <= 1'b1;
               r_state <= ST_SETUP;
            end
         end
      end
   end

endmodule

// File: tb/tb_ikascc_bus_sequencer.sv
// tb_ikascc_bus_sequencer: directed checks of the IKASCC bus sequencer.
// Four builds: main (2,RR), fixed prio (2,FP), STROBE_CYC 1 and 15.
module tb_ikascc_bus_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pcen_n = 1'b1;
   logic hold = 1'b0;
   int   pc = 0;

   logic [3:0][1:0] req = '0;
   logic [1:0]      we = '0;
   logic [15:0]     a0 = '0;
   logic [15:0]     a1 = '0;
   logic [7:0]      d0 = '0;
   logic [7:0]      d1 = '0;
   logic [7:0]      dbi = '0;

   wire [3:0][1:0]  ack;
   wire [3:0][7:0]  rdata;
   wire [3:0][7:0]  db;
   wire [3:0][15:0] ab;
   wire [3:0]       busy;
   wire [3:0]       cs_n;
   wire [3:0]       rd_n;
   wire [3:0]       wr_n;
   wire [3:0]       oe;

   int   checks = 0;
   int   errors = 0;
   logic both_low = 1'b0;
   int   nt;
   logic [1:0] a;

   always #5 clk = ~clk;

   // One tick every 8th clock; hold forces the enable inactive.
   always @(negedge clk) begin
      pc = pc + 1;
      pcen_n = hold ? 1'b1 : ((pc % 8) != 0);
   end

   always @(negedge clk)
      if (!rst && ((rd_n | wr_n) !== 4'hF)) both_low = 1'b1;

   ikascc_bus_sequencer #(.STROBE_CYC(2), .RR(1'b1)) u_m (
      .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
      .i_REQ(req[0]), .i_WE(we), .i_ADDR0(a0), .i_ADDR1(a1),
      .i_WDATA0(d0), .i_WDATA1(d1), .o_ACK(ack[0]), .o_RDATA(rdata[0]),
      .o_BUSY(busy[0]), .o_CS_n(cs_n[0]), .o_RD_n(rd_n[0]),
      .o_WR_n(wr_n[0]), .o_AB(ab[0]), .o_DB(db[0]), .o_DB_OE(oe[0]),
      .i_DB(dbi));

   ikascc_bus_sequencer #(.STROBE_CYC(2), .RR(1'b0)) u_fp (
      .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
      .i_REQ(req[1]), .i_WE(we), .i_ADDR0(a0), .i_ADDR1(a1),
      .i_WDATA0(d0), .i_WDATA1(d1), .o_ACK(ack[1]), .o_RDATA(rdata[1]),
      .o_BUSY(busy[1]), .o_CS_n(cs_n[1]), .o_RD_n(rd_n[1]),
      .o_WR_n(wr_n[1]), .o_AB(ab[1]), .o_DB(db[1]), .o_DB_OE(oe[1]),
      .i_DB(dbi));

   ikascc_bus_sequencer #(.STROBE_CYC(1), .RR(1'b1)) u_s1 (
      .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
      .i_REQ(req[2]), .i_WE(we), .i_ADDR0(a0), .i_ADDR1(a1),
      .i_WDATA0(d0), .i_WDATA1(d1), .o_ACK(ack[2]), .o_RDATA(rdata[2]),
      .o_BUSY(busy[2]), .o_CS_n(cs_n[2]), .o_RD_n(rd_n[2]),
      .o_WR_n(wr_n[2]), .o_AB(ab[2]), .o_DB(db[2]), .o_DB_OE(oe[2]),
      .i_DB(dbi));

   ikascc_bus_sequencer #(.STROBE_CYC(15), .RR(1'b1)) u_s15 (
      .i_EMUCLK(clk), .i_RST(rst), .i_MCLK_PCEN_n(pcen_n),
      .i_REQ(req[3]), .i_WE(we), .i_ADDR0(a0), .i_ADDR1(a1),
      .i_WDATA0(d0), .i_WDATA1(d1), .o_ACK(ack[3]), .o_RDATA(rdata[3]),
      .o_BUSY(busy[3]), .o_CS_n(cs_n[3]), .o_RD_n(rd_n[3]),
      .o_WR_n(wr_n[3]), .o_AB(ab[3]), .o_DB(db[3]), .o_DB_OE(oe[3]),
      .i_DB(dbi));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (pcen_n !== 1'b0);
      #1;
   endtask

   task automatic wait_ack(input int sel, input int maxt,
                           output int n, output logic [1:0] ak);
      ak = 2'b00;
      n = maxt + 1;
      for (int i = 1; i <= maxt; i++) begin
         wait_tick();
         if (ack[sel] !== 2'b00) begin
            ak = ack[sel];
            n = i;
            return;
         end
      end
   endtask

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs", 32'(cs_n[0]), 1);
      chk("rst_rd", 32'(rd_n[0]), 1);
      chk("rst_wr", 32'(wr_n[0]), 1);
      chk("rst_ab", 32'(ab[0]), 0);
      chk("rst_db", 32'(db[0]), 0);
      chk("rst_oe", 32'(oe[0]), 0);
      chk("rst_ack", 32'(ack[0]), 0);
      chk("rst_rdata", 32'(rdata[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      @(negedge clk) rst = 1'b0;

      // P0 write 9000h <- 3Fh
      we = 2'b01; a0 = 16'h9000; d0 = 8'h3F; req[0] = 2'b01;
      wait_tick();
      chk("w_t0_ab", 32'(ab[0]), 32'h9000);
      chk("w_t0_oe", 32'(oe[0]), 1);
      chk("w_t0_db", 32'(db[0]), 32'h3F);
      chk("w_t0_cs", 32'(cs_n[0]), 1);
      chk("w_t0_busy", 32'(busy[0]), 1);
      wait_tick();
      chk("w_t1_cs", 32'(cs_n[0]), 0);
      chk("w_t1_wr", 32'(wr_n[0]), 0);
      chk("w_t1_rd", 32'(rd_n[0]), 1);
      wait_tick();
      chk("w_t2_cs", 32'(cs_n[0]), 0);
      chk("w_t2_wr", 32'(wr_n[0]), 0);
      wait_tick();
      chk("w_t3_cs", 32'(cs_n[0]), 1);
      chk("w_t3_wr", 32'(wr_n[0]), 1);
      chk("w_t3_oe", 32'(oe[0]), 1);
      chk("w_t3_ack", 32'(ack[0]), 0);
      wait_tick();
      chk("w_t4_ack", 32'(ack[0]), 1);
      chk("w_t4_oe", 32'(oe[0]), 0);
      chk("w_t4_busy", 32'(busy[0]), 0);
      req[0] = 2'b00;
      @(posedge clk);
      #1;
      chk("w_ack_width", 32'(ack[0]), 0);

      // P1 read 9860h, slave returns A5h
      we = 2'b00; a1 = 16'h9860; dbi = 8'hA5; req[0] = 2'b10;
      wait_tick();
      chk("r_t0_ab", 32'(ab[0]), 32'h9860);
      chk("r_t0_oe", 32'(oe[0]), 0);
      wait_tick();
      chk("r_t1_rd", 32'(rd_n[0]), 0);
      chk("r_t1_wr", 32'(wr_n[0]), 1);
      chk("r_t1_cs", 32'(cs_n[0]), 0);
      wait_tick();
      chk("r_t2_rd", 32'(rd_n[0]), 0);
      chk("r_t2_wr", 32'(wr_n[0]), 1);
      wait_tick();
      chk("r_t3_rd", 32'(rd_n[0]), 1);
      wait_tick();
      chk("r_t4_ack", 32'(ack[0]), 2);
      chk("r_t4_rdata", 32'(rdata[0]), 32'hA5);
      req[0] = 2'b00; dbi = 8'h00;
      wait_tick();
      chk("r_rdata_hold", 32'(rdata[0]), 32'hA5);
      chk("idle_ab_hold", 32'(ab[0]), 32'h9860);

      // round robin: P0 alone, then tie -> 1,0,1,0 back to back
      we = 2'b11; a0 = 16'h1111; a1 = 16'h2222; d0 = 8'h11; d1 = 8'h22;
      req[0] = 2'b01;
      wait_ack(0, 8, nt, a);
      chk("rr_solo_ack", 32'(a), 1);
      req[0] = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_ack(0, 8, nt, a);
         chk($sformatf("rr_ack%0d", k), 32'(a), (k % 2 == 0) ? 2 : 1);
         chk($sformatf("rr_ticks%0d", k), 32'(nt), (k == 0) ? 5 : 4);
         if (k < 3)
            chk($sformatf("rr_next_ab%0d", k), 32'(ab[0]),
                (k % 2 == 0) ? 32'h1111 : 32'h2222);
         if (k == 2) req[0] = 2'b01;
         if (k == 3) req[0] = 2'b00;
      end
      wait_tick();
      chk("rr_end_busy", 32'(busy[0]), 0);

      // fixed priority: P0 alone, then tie -> 0 then 1
      req[1] = 2'b01;
      wait_ack(1, 8, nt, a);
      chk("fp_solo_ack", 32'(a), 1);
      req[1] = 2'b11;
      wait_ack(1, 8, nt, a);
      chk("fp_tie_first", 32'(a), 1);
      chk("fp_tie_ticks", 32'(nt), 5);
      req[1] = 2'b10;
      wait_ack(1, 8, nt, a);
      chk("fp_tie_second", 32'(a), 2);
      chk("fp_second_ticks", 32'(nt), 4);
      req[1] = 2'b00;

      // freeze in ACTIVE for 20 clocks
      we = 2'b01; a0 = 16'h9ABC; d0 = 8'h5C; req[0] = 2'b01;
      wait_tick();
      wait_tick();
      chk("fz_t1_cs", 32'(cs_n[0]), 0);
      hold = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("fz_cs", 32'(cs_n[0]), 0);
      chk("fz_wr", 32'(wr_n[0]), 0);
      chk("fz_busy", 32'(busy[0]), 1);
      chk("fz_ab", 32'(ab[0]), 32'h9ABC);
      chk("fz_ack", 32'(ack[0]), 0);
      hold = 1'b0;
      wait_tick();
      chk("fz_t2_cs", 32'(cs_n[0]), 0);
      wait_tick();
      chk("fz_t3_cs", 32'(cs_n[0]), 1);
      wait_tick();
      chk("fz_t4_ack", 32'(ack[0]), 1);
      req[0] = 2'b00;

      // reset during ACTIVE of a write
      we = 2'b01; a0 = 16'h4321; d0 = 8'h77; req[0] = 2'b01;
      wait_tick();
      wait_tick();
      wait_tick();
      #2 rst = 1'b1;
      #1;
      chk("mr_cs", 32'(cs_n[0]), 1);
      chk("mr_wr", 32'(wr_n[0]), 1);
      chk("mr_oe", 32'(oe[0]), 0);
      chk("mr_busy", 32'(busy[0]), 0);
      req[0] = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      wait_ack(0, 6, nt, a);
      chk("mr_no_ack", 32'(a), 0);
      we = 2'b00; a1 = 16'h9800; dbi = 8'h5A; req[0] = 2'b10;
      wait_ack(0, 8, nt, a);
      chk("mr_next_ack", 32'(a), 2);
      chk("mr_next_ticks", 32'(nt), 5);
      chk("mr_next_rdata", 32'(rdata[0]), 32'h5A);
      req[0] = 2'b00;

      // STROBE_CYC = 1: ack at T3
      we = 2'b01; a0 = 16'h9001; d0 = 8'h01; req[2] = 2'b01;
      wait_ack(2, 8, nt, a);
      chk("s1_ack", 32'(a), 1);
      chk("s1_ticks", 32'(nt), 4);
      req[2] = 2'b00;

      // STROBE_CYC = 15: ack at T17
      we = 2'b00; a0 = 16'h9002; dbi = 8'hC3; req[3] = 2'b01;
      wait_ack(3, 24, nt, a);
      chk("s15_ack", 32'(a), 1);
      chk("s15_ticks", 32'(nt), 18);
      chk("s15_rdata", 32'(rdata[3]), 32'hC3);
      req[3] = 2'b00;

      chk("rd_wr_never_both_low", 32'(both_low), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
